// File: rtl/wb_scoreboard.sv
// Write-back stage register and per-register pending-write scoreboard.
// Drives the register-file write port and the decode hazard stall.
module wb_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic [4:0]  dec_rp,
  input  logic        dec_use_rs,
  input  logic        dec_use_rt,
  input  logic        dec_use_rp,
  input  logic        issue_valid,
  input  logic        issue_regw,
  input  logic [4:0]  dec_rd,
  input  logic        mem_valid,
  input  logic        mem_regw,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  mem_rp,
  input  logic [31:0] mem_pred_val,
  input  logic [1:0]  mem_wbsel,
  input  logic [31:0] mem_alu_res,
  input  logic [31:0] mem_load_data,
  input  logic [31:0] mem_link_pc,
  output logic        stall,
  output logic        RegW,
  output logic [4:0]  Rd,
  output logic [4:0]  Rp,
  output logic        RegPRes,
  output logic [31:0] BusW
);

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NREG     = 32;
  localparam int unsigned LINK_REG = 30;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Write-back payload captured from MEM every cycle.
  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rp;
    logic              pres;
    logic [DATA_W-1:0] data;
  } wb_reg_t;

  // R0 and the link register are protected by the register file; never tracked.
  function automatic logic f_tracked(input logic [REG_W-1:0] r);
    return (r != REG_W'(0)) && (r != REG_W'(LINK_REG));
  endfunction

  wb_reg_t r_wb;
  wb_reg_t w_wb_nxt;

  logic [NREG-1:0][CNT_W-1:0] w_cnt;
  logic w_rs_busy;
  logic w_rt_busy;
  logic w_rp_busy;
  logic w_rd_full;
  logic w_issue_acc;
  logic w_retire;

  // Result select and predicate resolution for the retiring instruction.
  always_comb begin
    w_wb_nxt      = '0;
    w_wb_nxt.we   = mem_valid & mem_regw;
    w_wb_nxt.rd   = mem_rd;
    w_wb_nxt.rp   = mem_rp;
    w_wb_nxt.pres = (mem_pred_val != '0);
    unique case (mem_wbsel)
      2'd1:    w_wb_nxt.data = mem_load_data;
      2'd2:    w_wb_nxt.data = mem_link_pc;
      default: w_wb_nxt.data = mem_alu_res;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb <= '0;
    end else begin
      r_wb <= w_wb_nxt;
    end
  end

  assign RegW    = r_wb.we;
  assign Rd      = r_wb.rd;
  assign Rp      = r_wb.rp;
  assign RegPRes = r_wb.pres;
  assign BusW    = r_wb.data;

  // Hazard detection: pending source, or destination already at max in-flight writes.
  assign w_rs_busy = dec_use_rs && (w_cnt[dec_rs] != '0);
  assign w_rt_busy = dec_use_rt && (w_cnt[dec_rt] != '0);
  assign w_rp_busy = dec_use_rp && (w_cnt[dec_rp] != '0);
  assign w_rd_full = issue_valid && issue_regw && (w_cnt[dec_rd] == CNT_MAX);
  assign stall     = w_rs_busy | w_rt_busy | w_rp_busy | w_rd_full;

  assign w_issue_acc = issue_valid && issue_regw && !stall && f_tracked(dec_rd);
  assign w_retire    = r_wb.we && f_tracked(r_wb.rd);

  for (genvar g = 0; g < NREG; g++) begin : g_cnt
    if ((g == 0) || (g == LINK_REG)) begin : g_untracked
      assign w_cnt[g] = '0;
    end else begin : g_tracked
      logic [CNT_W-1:0] r_cnt;
      logic             w_inc;
      logic             w_dec;

      assign w_inc = w_issue_acc && (dec_rd == REG_W'(g));
      assign w_dec = w_retire && (r_wb.rd == REG_W'(g));

      // Issue and retire on the same edge cancel; both ends saturate.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
        end else if (w_inc && !w_dec && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_dec && !w_inc && (r_cnt != '0)) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end

      assign w_cnt[g] = r_cnt;
    end
  end

  // A retire with nothing pending means the pipeline lost track of an issue.
  a_no_underflow : assert property (@(posedge clk) disable iff (!reset)
    !(w_retire && (w_cnt[r_wb.rd] == '0)));

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: table vectors, directed hazard sequences and
// randomized traffic checked against a queue-based in-flight model.
module tb_wb_scoreboard;

  localparam int CNT_W    = 2;
  localparam int MAX_PEND = (1 << CNT_W) - 1;

  logic        clk;
  logic        reset;
  logic [4:0]  dec_rs, dec_rt, dec_rp, dec_rd;
  logic        dec_use_rs, dec_use_rt, dec_use_rp;
  logic        issue_valid, issue_regw;
  logic        mem_valid, mem_regw;
  logic [4:0]  mem_rd, mem_rp;
  logic [31:0] mem_pred_val;
  logic [1:0]  mem_wbsel;
  logic [31:0] mem_alu_res, mem_load_data, mem_link_pc;
  logic        stall, RegW, RegPRes;
  logic [4:0]  Rd, Rp;
  logic [31:0] BusW;

  wb_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rp(dec_rp),
    .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_use_rp(dec_use_rp),
    .issue_valid(issue_valid), .issue_regw(issue_regw), .dec_rd(dec_rd),
    .mem_valid(mem_valid), .mem_regw(mem_regw), .mem_rd(mem_rd), .mem_rp(mem_rp),
    .mem_pred_val(mem_pred_val), .mem_wbsel(mem_wbsel),
    .mem_alu_res(mem_alu_res), .mem_load_data(mem_load_data), .mem_link_pc(mem_link_pc),
    .stall(stall), .RegW(RegW), .Rd(Rd), .Rp(Rp), .RegPRes(RegPRes), .BusW(BusW)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of destinations issued but not yet retired.
  logic [4:0]  outstanding[$];
  logic [4:0]  issued[$];
  logic        m_we, m_pres;
  logic [4:0]  m_rd, m_rp;
  logic [31:0] m_busw;

  function automatic bit tracked(input logic [4:0] r);
    return (r != 5'd0) && (r != 5'd30);
  endfunction

  function automatic int pending(input logic [4:0] r);
    int n = 0;
    foreach (outstanding[i]) if (outstanding[i] == r) n++;
    return n;
  endfunction

  function automatic bit exp_stall();
    return (dec_use_rs && pending(dec_rs) > 0) ||
           (dec_use_rt && pending(dec_rt) > 0) ||
           (dec_use_rp && pending(dec_rp) > 0) ||
           (issue_valid && issue_regw && pending(dec_rd) >= MAX_PEND);
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit st;
    bit acc;
    if (!reset) begin
      outstanding.delete();
      issued.delete();
      m_we = 1'b0; m_rd = '0; m_rp = '0; m_pres = 1'b0; m_busw = '0;
    end else begin
      st  = exp_stall();
      acc = issue_valid && !st && issue_regw && tracked(dec_rd);
      if (m_we && tracked(m_rd)) begin
        for (int i = 0; i < outstanding.size(); i++) begin
          if (outstanding[i] == m_rd) begin
            outstanding.delete(i);
            break;
          end
        end
      end
      if (acc) begin
        outstanding.push_back(dec_rd);
        issued.push_back(dec_rd);
      end
      m_we   = mem_valid && mem_regw;
      m_rd   = mem_rd;
      m_rp   = mem_rp;
      m_pres = (mem_pred_val != 32'd0);
      m_busw = (mem_wbsel == 2'd1) ? mem_load_data :
               (mem_wbsel == 2'd2) ? mem_link_pc : mem_alu_res;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall",   32'(stall),   32'(exp_stall()));
      chk("m_regw",    32'(RegW),    32'(m_we));
      chk("m_rd",      32'(Rd),      32'(m_rd));
      chk("m_rp",      32'(Rp),      32'(m_rp));
      chk("m_regpres", 32'(RegPRes), 32'(m_pres));
      chk("m_busw",    BusW,         m_busw);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        valid;
    logic        regw;
    logic [4:0]  rd;
    logic [4:0]  rp;
    logic [1:0]  wbsel;
    logic [31:0] alu;
    logic [31:0] load;
    logic [31:0] link;
    logic [31:0] pred;
    logic        exp_regw;
    logic [31:0] exp_busw;
    logic        exp_pres;
  } vec_t;

  vec_t vecs[6];

  task automatic idle_in();
    dec_rs = '0; dec_rt = '0; dec_rp = '0; dec_rd = '0;
    dec_use_rs = 1'b0; dec_use_rt = 1'b0; dec_use_rp = 1'b0;
    issue_valid = 1'b0; issue_regw = 1'b0;
    mem_valid = 1'b0; mem_regw = 1'b0; mem_rd = '0; mem_rp = '0;
    mem_pred_val = '0; mem_wbsel = '0;
    mem_alu_res = '0; mem_load_data = '0; mem_link_pc = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_regw = 1'b1; dec_rd = rd;
  endtask

  task automatic send_mem(input logic [4:0] rd);
    mem_valid = 1'b1; mem_regw = 1'b1; mem_rd = rd;
  endtask

  task automatic probe_rs(input string name, input logic [4:0] r, input logic exp);
    dec_use_rs = 1'b1; dec_rs = r;
    #1 chk(name, 32'(stall), 32'(exp));
    dec_use_rs = 1'b0;
  endtask

  function automatic logic [4:0] pick();
    int r = $urandom_range(0, 7);
    return (r == 7) ? 5'd30 : 5'(r);
  endfunction

  initial begin
    vecs[0] = '{1'b1, 1'b1, 5'd0,  5'd10, 2'd1, 32'h11111111, 32'hDEADBEEF, 32'h00000040, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 5'd30, 5'd0,  2'd2, 32'h00000001, 32'h00000002, 32'h00000040, 32'h5, 1'b1, 32'h00000040, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 5'd0,  5'd3,  2'd0, 32'h12345678, 32'h0BADF00D, 32'h00000044, 32'h1, 1'b0, 32'h12345678, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 5'd30, 5'd1,  2'd3, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000048, 32'h80000000, 1'b0, 32'hA5A5A5A5, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 5'd0,  5'd31, 2'd3, 32'hCAFEF00D, 32'h00000000, 32'h0000004C, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 5'd30, 5'd0,  2'd0, 32'h00000001, 32'hFFFFFFFF, 32'h00000050, 32'h0, 1'b1, 32'h00000001, 1'b0};

    // Reset held with MEM traffic present.
    idle_in();
    reset = 1'b0;
    send_mem(5'd5); mem_alu_res = 32'hFFFFFFFF; mem_pred_val = 32'd1; mem_rp = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_regw",    32'(RegW),    32'd0);
    chk("rst_rd",      32'(Rd),      32'd0);
    chk("rst_regpres", 32'(RegPRes), 32'd0);
    chk("rst_busw",    BusW,         32'd0);
    chk("rst_stall",   32'(stall),   32'd0);
    idle_in();
    reset = 1'b1;
    #1 chk("rst_rel_regw", 32'(RegW), 32'd0);
    chk("rst_rel_busw", BusW, 32'd0);
    for (int r = 0; r < 32; r++) probe_rs($sformatf("rst_cnt%0d", r), 5'(r), 1'b0);
    cyc();
    chk_en = 1'b1;

    // RAW hazard and write-back timing.
    idle_in(); issue(5'd5);
    #1 chk("raw_issue_ok", 32'(stall), 32'd0);
    cyc();
    idle_in(); dec_use_rs = 1'b1; dec_rs = 5'd5;
    send_mem(5'd5); mem_wbsel = 2'd0; mem_alu_res = 32'h1234;
    mem_load_data = 32'h5555; mem_link_pc = 32'h66;
    #1 chk("raw_stall", 32'(stall), 32'd1);
    cyc();
    mem_valid = 1'b0; mem_regw = 1'b0;
    #1 chk("raw_regw", 32'(RegW), 32'd1);
    chk("raw_rd", 32'(Rd), 32'd5);
    chk("raw_busw", BusW, 32'h00001234);
    chk("raw_stall_in_wb", 32'(stall), 32'd1);
    cyc();
    #1 chk("raw_release", 32'(stall), 32'd0);
    chk("raw_regw_off", 32'(RegW), 32'd0);

    // WAW up to saturation, release by one retire.
    for (int k = 0; k < 3; k++) begin
      idle_in(); issue(5'd9);
      #1 chk($sformatf("waw_issue%0d", k), 32'(stall), 32'd0);
      cyc();
    end
    idle_in(); issue(5'd9);
    #1 chk("waw_full", 32'(stall), 32'd1);
    cyc();
    send_mem(5'd9); mem_wbsel = 2'd2; mem_link_pc = 32'h900;
    #1 chk("waw_full_hold", 32'(stall), 32'd1);
    cyc();
    mem_valid = 1'b0; mem_regw = 1'b0;
    #1 chk("waw_full_wb", 32'(stall), 32'd1);
    chk("waw_wb_rd", 32'(Rd), 32'd9);
    chk("waw_wb_busw", BusW, 32'h900);
    cyc();
    #1 chk("waw_freed", 32'(stall), 32'd0);
    cyc();
    #1 chk("waw_cnt3", 32'(stall), 32'd1);
    idle_in();
    for (int k = 0; k < 3; k++) begin
      send_mem(5'd9);
      cyc();
    end
    idle_in();
    cyc(); cyc();
    probe_rs("waw_drained", 5'd9, 1'b0);

    // Predicate result passes through; retire happens regardless.
    for (int p = 0; p < 2; p++) begin
      idle_in(); issue(5'd7);
      cyc();
      idle_in(); send_mem(5'd7); mem_rp = 5'd10; mem_pred_val = 32'(p); mem_alu_res = 32'h77;
      cyc();
      idle_in();
      #1 chk($sformatf("pred%0d_regw", p), 32'(RegW), 32'd1);
      chk($sformatf("pred%0d_rp", p), 32'(Rp), 32'd10);
      chk($sformatf("pred%0d_pres", p), 32'(RegPRes), (p == 0) ? 32'd0 : 32'd1);
      probe_rs($sformatf("pred%0d_pending", p), 5'd7, 1'b1);
      cyc();
      probe_rs($sformatf("pred%0d_dec", p), 5'd7, 1'b0);
    end

    // Table: result select, predicate, write enable on untracked destinations.
    foreach (vecs[i]) begin
      idle_in();
      mem_valid = vecs[i].valid; mem_regw = vecs[i].regw;
      mem_rd = vecs[i].rd; mem_rp = vecs[i].rp; mem_wbsel = vecs[i].wbsel;
      mem_alu_res = vecs[i].alu; mem_load_data = vecs[i].load;
      mem_link_pc = vecs[i].link; mem_pred_val = vecs[i].pred;
      cyc();
      idle_in();
      #1 chk($sformatf("vec%0d_regw", i), 32'(RegW), 32'(vecs[i].exp_regw));
      chk($sformatf("vec%0d_busw", i), BusW, vecs[i].exp_busw);
      chk($sformatf("vec%0d_pres", i), 32'(RegPRes), 32'(vecs[i].exp_pres));
      chk($sformatf("vec%0d_rd", i), 32'(Rd), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_rp", i), 32'(Rp), 32'(vecs[i].rp));
    end

    // R0 and R30 never become pending.
    idle_in(); issue(5'd0); cyc();
    for (int k = 0; k < 4; k++) begin issue(5'd30); cyc(); end
    idle_in();
    dec_use_rs = 1'b1; dec_rs = 5'd0; dec_use_rt = 1'b1; dec_rt = 5'd30;
    dec_use_rp = 1'b1; dec_rp = 5'd30;
    #1 chk("untracked_src", 32'(stall), 32'd0);
    idle_in(); issue(5'd30);
    #1 chk("untracked_rd30", 32'(stall), 32'd0);
    issue(5'd0);
    #1 chk("untracked_rd0", 32'(stall), 32'd0);
    cyc();

    // Issue and retire to the same register on one edge.
    idle_in(); issue(5'd4); cyc();
    idle_in(); send_mem(5'd4); cyc();
    idle_in(); issue(5'd4);
    #1 chk("ovl_issue", 32'(stall), 32'd0);
    cyc();
    idle_in();
    probe_rs("ovl_pending", 5'd4, 1'b1);
    send_mem(5'd4); cyc();
    idle_in(); cyc();
    probe_rs("ovl_drained", 5'd4, 1'b0);

    // Reset mid-operation drops tracking immediately.
    idle_in(); issue(5'd12); send_mem(5'd0); mem_alu_res = 32'h55;
    cyc();
    idle_in();
    #1 chk("midrst_pre_regw", 32'(RegW), 32'd1);
    reset = 1'b0;
    #1 chk("midrst_regw", 32'(RegW), 32'd0);
    chk("midrst_busw", BusW, 32'd0);
    probe_rs("midrst_cnt", 5'd12, 1'b0);
    reset = 1'b1;
    cyc();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      issue_valid = 1'($urandom_range(0, 1));
      issue_regw  = ($urandom_range(0, 3) != 0);
      dec_rd = pick(); dec_rs = pick(); dec_rt = pick(); dec_rp = pick();
      dec_use_rs = ($urandom_range(0, 2) == 0);
      dec_use_rt = ($urandom_range(0, 2) == 0);
      dec_use_rp = ($urandom_range(0, 3) == 0);
      if (issued.size() > 0 && $urandom_range(0, 2) != 0) begin
        send_mem(issued.pop_front());
      end else begin
        mem_valid = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
          mem_regw = 1'b0; mem_rd = 5'($urandom);
        end else begin
          mem_regw = 1'b1; mem_rd = ($urandom_range(0, 1) == 1) ? 5'd0 : 5'd30;
        end
      end
      mem_rp        = 5'($urandom);
      mem_pred_val  = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
      mem_wbsel     = 2'($urandom);
      mem_alu_res   = $urandom;
      mem_load_data = $urandom;
      mem_link_pc   = $urandom;
      cyc();
    end

    // Drain everything in flight, then every counter must read idle.
    idle_in();
    for (int c = 0; c < 200 && issued.size() > 0; c++) begin
      send_mem(issued.pop_front());
      cyc();
    end
    idle_in();
    if (issued.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 entries left", issued.size());
    end
    repeat (3) cyc();
    chk_en = 1'b0;
    for (int r = 0; r < 32; r++) probe_rs($sformatf("final_cnt%0d", r), 5'(r), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
